// File: rtl/muldiv_hilo_unit.sv
// Multiply/divide unit with architectural HI/LO: single-cycle MULT/MULTU, iterative restoring DIV/DIVU.
// Optional macro MULDIV_EARLY_OUT_EN: divides with b=0 or |a|<|b| finish at the start edge.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed, a_neg, b_neg, early, last;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     shifted, diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_nx, quo_nx;

    always_comb begin
        is_signed = ~op_i[0];
        a_neg     = is_signed & a_i[WIDTH-1];
        b_neg     = is_signed & b_i[WIDTH-1];
        a_abs     = a_neg ? -a_i : a_i;
        b_abs     = b_neg ? -b_i : b_i;
        // Sign-extending to 2*WIDTH lets one unsigned multiply serve both MULT and MULTU.
        a_ext     = {{WIDTH{a_neg}}, a_i};
        b_ext     = {{WIDTH{b_neg}}, b_i};
        prod      = a_ext * b_ext;
        early     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        early     = (b_i == '0) || (a_abs < b_abs);
`endif
        // Restoring step: remainder never exceeds the divisor, so bit WIDTH of diff is the borrow.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, div_q};
        qbit      = ~diff[WIDTH];
        rem_nx    = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], qbit};
        last      = (count_q == CNT_W'(WIDTH - 1));

        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    if (!op_i[1]) begin
                        {hi_d, lo_d} = prod;
                        done_d       = 1'b1;
                    end else if (early) begin
                        hi_d   = a_i;
                        lo_d   = (b_i == '0) ? '1 : '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = a_abs;
                        div_d   = b_abs;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        bzero_d = (b_i == '0);
                    end
                end else if (!start_i) begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                end
            end
            BUSY: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_nx;
                    quo_d   = quo_nx;
                    count_d = count_q + 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        // A zero divisor yields remainder |a|; the dividend-sign fixup restores a.
                        lo_d    = bzero_q ? '1 : (qneg_q ? -quo_nx : quo_nx);
                        hi_d    = rneg_q ? -rem_nx : rem_nx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        stall_o = ((state_q == IDLE) && start_i && op_i[1] && !cancel_i && !early) ||
                  ((state_q == BUSY) && !cancel_i && !last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign done_o = done_q;
endmodule
